reg_read_stage: RTL and testbench

Register-file read stage sitting directly downstream of the bit-cell array: it decodes two 4-bit source-register numbers into one-hot per-register read enables, samples the two shared read bitlines, and registers the resolved operands into the decode/execute boundary. It resolves same-cycle write-back hazards, either by bypassing write-back data or by re-reading a cycle later. It also honours pipeline stall and flush, and forces R0 to read as zero.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/reg_decoder.sv | 10 +
 rtl/reg_read_stage.sv | 87 ++++++++
 tb/tb_reg_read_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, FSM state type and zero-register number for the register read stage
package regfile_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  typedef enum logic {RD_READ, RD_REREAD} rd_state_t;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
endpackage

// File: rtl/reg_decoder.sv
// reg_decoder: ADDR_W-to-NUM_REGS one-hot decoder with enable; R0 never selected (ports: i_en, i_addr, o_onehot)
module reg_decoder
  import regfile_pkg::*;
(
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);
  assign o_onehot = (i_en && i_addr != ZERO_REG) ? NUM_REGS'(1) << i_addr : '0;
endmodule

// File: rtl/reg_read_stage.sv
// reg_read_stage: two-port register read stage with R0=0, write-back hazard handling (bypass when REGREAD_BYPASS_EN is defined, else one-cycle re-read), stall and flush.
// Ports: clk, rst (async active-low); request in_valid/in_ready/src_reg1/src_reg2; array read_en1/read_en2/bitline1/bitline2;
// write-back wb_en/wb_reg/wb_data; pipeline control stall/flush; results out_valid/op1/op2/out_src1/out_src2.
module reg_read_stage
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   src_reg1,
  input  logic [ADDR_W-1:0]   src_reg2,
  output logic [NUM_REGS-1:0] read_en1,
  output logic [NUM_REGS-1:0] read_en2,
  input  logic [DATA_W-1:0]   bitline1,
  input  logic [DATA_W-1:0]   bitline2,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                stall,
  input  logic                flush,
  output logic                out_valid,
  output logic [DATA_W-1:0]   op1,
  output logic [DATA_W-1:0]   op2,
  output logic [ADDR_W-1:0]   out_src1,
  output logic [ADDR_W-1:0]   out_src2
);
`ifdef REGREAD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_lat1, r_lat2, r_src1, r_src2;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic              r_valid;
  logic              w_reread, w_haz1, w_haz2, w_block, w_accept, w_en;
  logic [ADDR_W-1:0] w_a1, w_a2;
  logic [DATA_W-1:0] w_d1, w_d2;
  assign w_reread = r_state == RD_REREAD;
  // In REREAD the latched registers already hold post-write values, so hazards are ignored there.
  assign w_haz1   = !w_reread && wb_en && wb_reg == src_reg1 && src_reg1 != ZERO_REG;
  assign w_haz2   = !w_reread && wb_en && wb_reg == src_reg2 && src_reg2 != ZERO_REG;
  assign w_block  = (w_haz1 || w_haz2) && !BYPASS;
  assign in_ready = !stall && !w_reread && !w_block;
  assign w_accept = in_valid && in_ready;
  assign w_en     = rst && (w_reread || (in_valid && !stall));
  assign w_a1     = w_reread ? r_lat1 : src_reg1;
  assign w_a2     = w_reread ? r_lat2 : src_reg2;
  assign w_d1     = w_a1 == ZERO_REG ? '0 : (w_haz1 && BYPASS) ? wb_data : bitline1;
  assign w_d2     = w_a2 == ZERO_REG ? '0 : (w_haz2 && BYPASS) ? wb_data : bitline2;
  reg_decoder u_dec1 (.i_en(w_en), .i_addr(w_a1), .o_onehot(read_en1));
  reg_decoder u_dec2 (.i_en(w_en), .i_addr(w_a2), .o_onehot(read_en2));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RD_READ;
      r_valid <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_lat1  <= '0;
      r_lat2  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_state <= RD_READ;
    end else if (!stall) begin
      r_valid <= w_reread || w_accept;
      r_state <= (!w_reread && in_valid && w_block) ? RD_REREAD : RD_READ;
      if (!w_reread) begin
        r_lat1 <= src_reg1;
        r_lat2 <= src_reg2;
      end
      if (w_reread || w_accept) begin
        r_op1  <= w_d1;
        r_op2  <= w_d2;
        r_src1 <= w_a1;
        r_src2 <= w_a2;
      end
    end
  end
  assign out_valid = r_valid;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign out_src1  = r_src1;
  assign out_src2  = r_src2;
endmodule

// File: tb/tb_reg_read_stage.sv
// tb_reg_read_stage: randomized self-checking bench with a register-array model driving the bitlines
module tb_reg_read_stage;
  import regfile_pkg::*;
`ifdef REGREAD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_ready, wb_en = 1'b0, stall = 1'b0, flush = 1'b0, out_valid;
  logic [ADDR_W-1:0] src_reg1 = '0, src_reg2 = '0, wb_reg = '0, out_src1, out_src2;
  logic [NUM_REGS-1:0] read_en1, read_en2;
  logic [DATA_W-1:0] bitline1, bitline2, wb_data = '0, op1, op2, bl1, bl2;
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic force_bl1 = 1'b0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  reg_read_stage dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src_reg1(src_reg1), .src_reg2(src_reg2), .read_en1(read_en1), .read_en2(read_en2),
    .bitline1(bitline1), .bitline2(bitline2), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .stall(stall), .flush(flush), .out_valid(out_valid), .op1(op1), .op2(op2),
    .out_src1(out_src1), .out_src2(out_src2));

  always_comb begin
    bl1 = '0;
    bl2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (read_en1[i]) bl1 = mem[i];
      if (read_en2[i]) bl2 = mem[i];
    end
  end
  assign bitline1 = force_bl1 ? 16'hFFFF : bl1;
  assign bitline2 = bl2;

  task automatic tick();
    @(posedge clk);
    #1;
    if (wb_en) mem[wb_reg] = wb_data;
  endtask

  task automatic idle();
    in_valid = 1'b0; wb_en = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; src_reg1 = 4'd3; src_reg2 = 4'd7;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    tests++; if (op1 !== 16'h0 || op2 !== 16'h0) begin fails++; $display("FAIL rst_ops got %h/%h exp 0/0", op1, op2); end
    tests++; if (read_en1 !== '0 || read_en2 !== '0) begin fails++; $display("FAIL rst_read_en got %h/%h exp 0/0", read_en1, read_en2); end
    tick();
    rst = 1'b1;
    mem[5] = 16'h1111;
    in_valid = 1'b1; src_reg1 = 4'd5; src_reg2 = 4'd0;
    wb_en = 1'b1; wb_reg = 4'd5; wb_data = 16'hAAAA;
    tick();
    idle();
    #1;
    if (!BYP) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_reread got in_ready %b exp 0", in_ready); end
    end
    rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || op1 !== 16'h0 || op2 !== 16'h0) begin fails++; $display("FAIL rst_mid got valid %b ops %h/%h exp 0 0/0", out_valid, op1, op2); end
    tests++; if (read_en1 !== '0 || read_en2 !== '0) begin fails++; $display("FAIL rst_mid_read_en got %h/%h exp 0/0", read_en1, read_en2); end
    #2 rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_no_resume got valid %b exp 0", out_valid); end
  endtask

  task automatic test_plain();
    mem[3] = 16'h1234; mem[7] = 16'hBEEF;
    in_valid = 1'b1; src_reg1 = 4'd3; src_reg2 = 4'd7;
    #1;
    tests++; if (read_en1 !== 16'h0008 || read_en2 !== 16'h0080) begin fails++; $display("FAIL plain_read_en got %h/%h exp 0008/0080", read_en1, read_en2); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL plain_ready got %b exp 1", in_ready); end
    tick();
    idle();
    tests++; if (out_valid !== 1'b1 || op1 !== 16'h1234 || op2 !== 16'hBEEF) begin fails++; $display("FAIL plain_ops got %b %h/%h exp 1 1234/beef", out_valid, op1, op2); end
    tests++; if (out_src1 !== 4'd3 || out_src2 !== 4'd7) begin fails++; $display("FAIL plain_src got %0d/%0d exp 3/7", out_src1, out_src2); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL plain_idle got valid %b exp 0", out_valid); end
  endtask

  task automatic test_r0();
    mem[0] = 16'h5555;
    force_bl1 = 1'b1;
    in_valid = 1'b1; src_reg1 = 4'd0; src_reg2 = 4'd7;
    #1;
    tests++; if (read_en1 !== '0) begin fails++; $display("FAIL r0_read_en got %h exp 0000", read_en1); end
    tick();
    idle();
    force_bl1 = 1'b0;
    tests++; if (out_valid !== 1'b1 || op1 !== 16'h0 || op2 !== 16'hBEEF) begin fails++; $display("FAIL r0_ops got %b %h/%h exp 1 0000/beef", out_valid, op1, op2); end
  endtask

  task automatic test_hazard(input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                             input logic [DATA_W-1:0] nv);
    logic [DATA_W-1:0] e1, e2;
    mem[s1] = 16'h1111;
    mem[s2] = (s1 == s2) ? 16'h1111 : 16'h2222;
    e1 = (s1 == 0) ? 16'h0 : nv;
    e2 = (s2 == 0) ? 16'h0 : (s2 == s1) ? nv : mem[s2];
    in_valid = 1'b1; src_reg1 = s1; src_reg2 = s2;
    wb_en = 1'b1; wb_reg = s1; wb_data = nv;
    #1;
    tests++; if (in_ready !== BYP) begin fails++; $display("FAIL haz_ready_t got %b exp %b", in_ready, BYP); end
    tick();
    idle();
    if (!BYP) begin
      #1;
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL haz_t1 got ready %b valid %b exp 0 0", in_ready, out_valid); end
      tests++; if (read_en1 !== NUM_REGS'(1) << s1) begin fails++; $display("FAIL haz_reread_en got %h exp bit %0d", read_en1, s1); end
      tick();
    end
    tests++; if (out_valid !== 1'b1 || op1 !== e1 || op2 !== e2) begin fails++; $display("FAIL haz_ops got %b %h/%h exp 1 %h/%h", out_valid, op1, op2, e1, e2); end
    tests++; if (out_src1 !== s1 || out_src2 !== s2) begin fails++; $display("FAIL haz_src got %0d/%0d exp %0d/%0d", out_src1, out_src2, s1, s2); end
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL haz_ready_after got %b exp 1", in_ready); end
  endtask

  task automatic test_stall_flush();
    logic [DATA_W-1:0] h1, h2;
    mem[2] = 16'h2B2B; mem[4] = 16'h4D4D;
    in_valid = 1'b1; src_reg1 = 4'd2; src_reg2 = 4'd4;
    tick();
    h1 = op1; h2 = op2;
    tests++; if (out_valid !== 1'b1 || h1 !== 16'h2B2B || h2 !== 16'h4D4D) begin fails++; $display("FAIL stall_pre got %b %h/%h exp 1 2b2b/4d4d", out_valid, h1, h2); end
    stall = 1'b1; src_reg1 = 4'd7; src_reg2 = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (in_ready !== 1'b0 || read_en1 !== '0) begin fails++; $display("FAIL stall_ctl got ready %b read_en %h exp 0 0000", in_ready, read_en1); end
      tick();
      tests++; if (out_valid !== 1'b1 || op1 !== 16'h2B2B || op2 !== 16'h4D4D) begin fails++; $display("FAIL stall_hold got %b %h/%h exp 1 2b2b/4d4d", out_valid, op1, op2); end
    end
    flush = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || op1 !== 16'h2B2B) begin fails++; $display("FAIL flush_stall got %b %h exp 0 2b2b", out_valid, op1); end
    idle();
    mem[6] = 16'h6666;
    in_valid = 1'b1; src_reg1 = 4'd6; src_reg2 = 4'd0;
    wb_en = 1'b1; wb_reg = 4'd6; wb_data = 16'h7777;
    tick();
    idle();
    flush = 1'b1;
    tick();
    idle();
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_reread got valid %b ready %b exp 0 1", out_valid, in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_after got valid %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] e1, e2;
    for (int i = 0; i < NUM_REGS; i++) mem[i] = DATA_W'($urandom);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      src_reg1 = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      src_reg2 = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      e1 = (src_reg1 == 0) ? 16'h0 : mem[src_reg1];
      e2 = (src_reg2 == 0) ? 16'h0 : mem[src_reg2];
      tick();
      tests++; if (out_valid !== 1'b1 || op1 !== e1 || op2 !== e2) begin fails++; $display("FAIL b2b_%0d got %b %h/%h exp 1 %h/%h", i, out_valid, op1, op2, e1, e2); end
    end
    idle();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got valid %b exp 0", out_valid); end
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 16'h0;
    test_reset();
    test_plain();
    test_r0();
    test_hazard(4'd5, 4'd3, 16'hAAAA);
    test_hazard(4'd9, 4'd9, 16'h5A5A);
    test_hazard(4'd12, 4'd0, DATA_W'($urandom));
    test_stall_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
